fetch_queue_unit: RTL and testbench

- Parametrised fetch stage that decouples PC generation from decode.
- Issues sequential fetches to a synchronous instruction memory with one-cycle read latency. Each returned instruction is tagged with its PC and held in a small FIFO.
- Decode drains the FIFO through a valid/ready handshake.
- Supports branch redirect with flush, stall via enable, and programmable reset PC and PC step.

---
 rtl/fetch_queue_unit.sv | 121 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Fetch stage that decouples PC generation from decode. Sequential fetches go to a
// synchronous instruction memory with one-cycle read latency. Each returned word is tagged
// with its PC and queued in a small FIFO that decode drains through valid/ready.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   enable                  permits new fetch requests (0 = fetch stall)
//   redirect_valid/_pc      branch/jump redirect: flush queue, restart fetch at redirect_pc
//   mem_req, mem_addr       read request and address to instruction memory
//   mem_rdata               read data, valid the cycle after an accepted mem_req
//   instruction_valid       FIFO head valid
//   instruction(_pc)        FIFO head word and its PC (zero when empty)
//   decode_ready            decode consumes the head this cycle
//   queue_count             FIFO occupancy, 0..QUEUE_DEPTH
module fetch_queue_unit #(
  parameter int unsigned          PC_WIDTH          = 32,
  parameter int unsigned          INSTRUCTION_WIDTH = 30,
  parameter int unsigned          QUEUE_DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC          = '0,
  parameter int unsigned          PC_STEP           = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          redirect_valid,
  input  logic [PC_WIDTH-1:0]           redirect_pc,
  output logic                          mem_req,
  output logic [PC_WIDTH-1:0]           mem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0]  mem_rdata,
  output logic                          instruction_valid,
  output logic [INSTRUCTION_WIDTH-1:0]  instruction,
  output logic [PC_WIDTH-1:0]           instruction_pc,
  input  logic                          decode_ready,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [OccW-1:0]     DepthOcc = OccW'(QUEUE_DEPTH);
  localparam logic [PC_WIDTH-1:0] StepPc   = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0]          fetch_pc_q;
  logic                         inflight_q;
  logic                         kill_q;
  logic [PC_WIDTH-1:0]          tag_q;
  logic [PtrW-1:0]              rd_ptr_q;
  logic [PtrW-1:0]              wr_ptr_q;
  logic [CntW-1:0]              count_q;
  logic [INSTRUCTION_WIDTH-1:0] buf_instr_q [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0]          buf_pc_q    [QUEUE_DEPTH];

  logic [OccW-1:0] occupancy;
  logic            push;
  logic            pop;

  // Occupancy includes the in-flight slot and ignores a same-cycle pop, so a response
  // always has room when it lands.
  always_comb begin
    occupancy = OccW'(count_q) + OccW'(inflight_q);
    mem_req   = enable & ~redirect_valid & ~reset & (occupancy < DepthOcc);
    mem_addr  = fetch_pc_q;
    push      = inflight_q & ~kill_q & ~redirect_valid & ~reset;
    pop       = instruction_valid & decode_ready & ~redirect_valid & ~reset;
  end

  always_comb begin
    instruction_valid = (count_q != '0);
    queue_count       = count_q;
    instruction       = '0;
    instruction_pc    = '0;
    if (instruction_valid) begin
      instruction    = buf_instr_q[rd_ptr_q];
      instruction_pc = buf_pc_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      tag_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      // An outstanding request stays accounted for but its data is dropped.
      inflight_q <= inflight_q;
      kill_q     <= inflight_q;
    end else begin
      inflight_q <= mem_req;
      kill_q     <= 1'b0;
      if (mem_req) begin
        fetch_pc_q <= fetch_pc_q + StepPc;
        tag_q      <= fetch_pc_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible through count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= mem_rdata;
      buf_pc_q[wr_ptr_q]    <= tag_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  localparam logic [31:0] ResetPc = 32'h10;

  logic        clock = 1'b0;
  logic        reset, enable, redirect_valid, decode_ready;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [29:0] mem_rdata;
  logic        instruction_valid;
  logic [29:0] instruction;
  logic [31:0] instruction_pc;
  logic [2:0]  queue_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fetch_queue_unit #(
    .PC_WIDTH(32), .INSTRUCTION_WIDTH(30), .QUEUE_DEPTH(4), .RESET_PC(ResetPc), .PC_STEP(1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instruction_valid(instruction_valid), .instruction(instruction),
    .instruction_pc(instruction_pc), .decode_ready(decode_ready), .queue_count(queue_count)
  );

  function automatic logic [29:0] word_of(input logic [31:0] a);
    return a[29:0] ^ 30'h15555555;
  endfunction

  // Memory: one-cycle latency; garbage when not requested.
  always @(posedge clock) begin
    if (mem_req) mem_rdata <= word_of(mem_addr);
    else         mem_rdata <= 30'($urandom);
  end

  // Behavioural model: queue of (pc, word), next fetch pc, one outstanding request.
  typedef struct { logic [31:0] pc; logic [29:0] ins; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_out;
  logic [31:0] m_opc;

  function automatic bit exp_req();
    return enable && !redirect_valid && !reset && ((q.size() + int'(m_out)) < 4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit req;
    req = exp_req();
    if (reset) begin
      q.delete(); m_pc = ResetPc; m_out = 0;
    end else if (redirect_valid) begin
      q.delete(); m_pc = redirect_pc; m_out = 0;
    end else begin
      if (q.size() > 0 && decode_ready) void'(q.pop_front());
      if (m_out) q.push_back('{pc: m_opc, ins: word_of(m_opc)});
      if (req) begin
        m_out = 1; m_opc = m_pc; m_pc = m_pc + 32'd1;
      end else begin
        m_out = 0;
      end
    end
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic cycle();
    #1;
    chk("mem_req", 64'(mem_req), 64'(exp_req()));
    chk("mem_addr", 64'(mem_addr), 64'(m_pc));
    chk("instruction_valid", 64'(instruction_valid), 64'(q.size() != 0));
    chk("instruction", 64'(instruction), (q.size() != 0) ? 64'(q[0].ins) : 64'd0);
    chk("instruction_pc", 64'(instruction_pc), (q.size() != 0) ? 64'(q[0].pc) : 64'd0);
    chk("queue_count", 64'(queue_count), 64'(q.size()));
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic rst();
    reset = 1; enable = 0; redirect_valid = 0; decode_ready = 0;
    cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1; enable = 0; redirect_valid = 0; decode_ready = 0; redirect_pc = '0;
    @(posedge clock);
    q.delete(); m_pc = ResetPc; m_out = 0; m_opc = '0;
    @(negedge clock);
    rst();

    // Streaming from reset PC.
    enable = 1; decode_ready = 1;
    #1 chk("pin_first_addr", 64'(mem_addr), 64'h10);
    chk("pin_first_req", 64'(mem_req), 64'd1);
    cycle(); cycle();
    #1 chk("pin_first_valid", 64'(instruction_valid), 64'd1);
    chk("pin_first_pc", 64'(instruction_pc), 64'h10);
    chk("pin_first_ins", 64'(instruction), 64'(30'h10 ^ 30'h15555555));
    chk("pin_stream_addr", 64'(mem_addr), 64'h12);
    repeat (6) cycle();

    // Back-pressure fills the queue.
    rst();
    enable = 1; decode_ready = 0;
    repeat (8) cycle();
    #1 chk("pin_full_count", 64'(queue_count), 64'd4);
    chk("pin_full_head", 64'(instruction_pc), 64'h10);
    chk("pin_full_req", 64'(mem_req), 64'd0);
    decode_ready = 1;
    repeat (8) cycle();

    // Redirect with one in flight and two queued.
    rst();
    enable = 1; decode_ready = 0;
    repeat (3) cycle();
    #1 chk("pin_pre_redirect_count", 64'(queue_count), 64'd2);
    redirect_valid = 1; redirect_pc = 32'h80;
    cycle();
    redirect_valid = 0;
    #1 chk("pin_redirect_count", 64'(queue_count), 64'd0);
    chk("pin_redirect_addr", 64'(mem_addr), 64'h80);
    chk("pin_redirect_req", 64'(mem_req), 64'd1);
    cycle(); cycle();
    #1 chk("pin_redirect_head", 64'(instruction_pc), 64'h80);

    // Redirect with simultaneous pop: nothing consumed, queue empty.
    decode_ready = 1; redirect_valid = 1; redirect_pc = 32'h90;
    cycle();
    redirect_valid = 0; decode_ready = 0;
    #1 chk("pin_redirect_pop_count", 64'(queue_count), 64'd0);

    // Stall with one request outstanding.
    cycle();
    enable = 0;
    repeat (3) cycle();
    #1 chk("pin_stall_count", 64'(queue_count), 64'd1);
    chk("pin_stall_req", 64'(mem_req), 64'd0);
    chk("pin_stall_addr", 64'(mem_addr), 64'h91);
    chk("pin_stall_head", 64'(instruction_pc), 64'h90);

    // PC wrap-around.
    enable = 1; decode_ready = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    cycle();
    redirect_valid = 0;
    #1 chk("pin_wrap_top", 64'(mem_addr), 64'hFFFF_FFFF);
    cycle();
    #1 chk("pin_wrap_zero", 64'(mem_addr), 64'h0);
    repeat (3) cycle();

    // Reset while the queue is busy and a request is in flight.
    rst();
    enable = 1; decode_ready = 0;
    repeat (4) cycle();
    reset = 1;
    cycle();
    reset = 0; enable = 0;
    #1 chk("pin_midreset_count", 64'(queue_count), 64'd0);
    chk("pin_midreset_valid", 64'(instruction_valid), 64'd0);
    chk("pin_midreset_addr", 64'(mem_addr), 64'(ResetPc));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 99) < 1);
      redirect_valid = ($urandom_range(0, 99) < 7);
      enable         = ($urandom_range(0, 99) < 80);
      decode_ready   = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: redirect_pc = $urandom;
      endcase
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
